// File: rtl/vliw_mem_banked_if.sv
// Request/response bus between the unified memory and its LSU/fetch clients.
// master = LSU + fetch side, slave = memory side.
interface vliw_mem_banked_if #(
  parameter int ADDR_W       = 32,
  parameter int BUNDLE_WORDS = 4
);
  logic                      lsu_req;
  logic                      lsu_we;
  logic [3:0]                lsu_be;
  logic [ADDR_W-1:0]         lsu_addr;
  logic [31:0]               lsu_wdata;
  logic                      lsu_ready;
  logic                      lsu_rvalid;
  logic [31:0]               lsu_rdata;
  logic                      lsu_err;
  logic                      if_req;
  logic [ADDR_W-1:0]         if_pc;
  logic                      if_ready;
  logic                      if_valid;
  logic [32*BUNDLE_WORDS-1:0] if_bundle;
  logic                      if_err;

  modport master (
    output lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
    input  lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
    output if_req, if_pc,
    input  if_ready, if_valid, if_bundle, if_err
  );

  modport slave (
    input  lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
    output lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
    input  if_req, if_pc,
    output if_ready, if_valid, if_bundle, if_err
  );
endinterface

// File: rtl/vliw_mem_banked.sv
// Unified I/D memory: one byte-enabled LSU port plus one bundle fetch port,
// stored as BUNDLE_WORDS word-interleaved banks, hardware-cleared after reset.
module vliw_mem_banked #(
  parameter int DEPTH_WORDS  = 256,
  parameter int BUNDLE_WORDS = 4,
  parameter int ADDR_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  vliw_mem_banked_if.slave   bus,
  output logic               init_done
);

  localparam int ROWS  = DEPTH_WORDS / BUNDLE_WORDS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BSH   = $clog2(BUNDLE_WORDS);
  localparam int BSW   = (BSH > 0) ? BSH : 1;
  localparam int OFF_W = BSH + 2;
  localparam int IW    = ADDR_W - 2;
  localparam int SPAN  = BUNDLE_WORDS - 1;
  localparam int LAST  = ROWS - 1;
  localparam logic [IW:0] DEPTH_C = DEPTH_WORDS[IW:0];
  localparam logic [IW:0] SPAN_C  = SPAN[IW:0];
  localparam logic [RW-1:0] LAST_C = LAST[RW-1:0];

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                    state_q;
  logic [RW-1:0]             clr_q;
  logic                      ready_q;
  logic                      lrv_q;
  logic                      lerr_q;
  logic [31:0]               lrd_q;
  logic                      fv_q;
  logic                      ferr_q;
  logic [32*BUNDLE_WORDS-1:0] fbun_q;
  logic [32*BUNDLE_WORDS-1:0] fbun_d;

  logic [IW-1:0]  lidx;
  logic [IW-1:0]  fidx;
  logic [RW-1:0]  lrow;
  logic [RW-1:0]  frow;
  logic [BSW-1:0] lbank;
  logic           lerr;
  logic           ferr;
  logic           lsu_acc;
  logic           if_acc;
  logic           st_en;
  logic           init_en;
  logic [31:0]    lrd [BUNDLE_WORDS];
  logic [31:0]    frd [BUNDLE_WORDS];

  assign lidx  = bus.lsu_addr[ADDR_W-1:2];
  assign fidx  = bus.if_pc[ADDR_W-1:2];
  assign lrow  = RW'(lidx >> BSH);
  assign frow  = RW'(fidx >> BSH);
  assign lbank = BSW'(lidx & IW'(SPAN));

  assign lerr = (|bus.lsu_addr[1:0]) |
                ({1'b0, lidx} >= DEPTH_C);
  // Range test uses one extra bit so index+span cannot wrap.
  assign ferr = (|bus.if_pc[OFF_W-1:0]) |
                (({1'b0, fidx} + SPAN_C) >= DEPTH_C);

  assign lsu_acc = bus.lsu_req & ready_q;
  assign if_acc  = bus.if_req & ready_q;
  assign st_en   = lsu_acc & bus.lsu_we & ~lerr;
  assign init_en = (state_q == S_INIT);

  for (genvar b = 0; b < BUNDLE_WORDS; b++) begin : g_bank
    logic [31:0] mem_q [ROWS];
    logic [31:0] merged;
    logic        hit;

    assign hit = st_en && (lbank == BSW'(b));

    always_comb begin
      merged = mem_q[lrow];
      for (int k = 0; k < 4; k++) begin
        if (bus.lsu_be[k]) merged[8*k +: 8] = bus.lsu_wdata[8*k +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (init_en) begin
        mem_q[clr_q] <= '0;
      end else if (hit) begin
        mem_q[lrow] <= merged;
      end
    end

    assign lrd[b] = mem_q[lrow];
    assign frd[b] = mem_q[frow];
  end

  always_comb begin
    fbun_d = '0;
    for (int i = 0; i < BUNDLE_WORDS; i++) begin
      fbun_d[32*i +: 32] = frd[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      clr_q   <= '0;
      ready_q <= 1'b0;
      lrv_q   <= 1'b0;
      lerr_q  <= 1'b0;
      lrd_q   <= '0;
      fv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      fbun_q  <= '0;
    end else begin
      lrv_q <= lsu_acc;
      fv_q  <= if_acc;
      if (lsu_acc) begin
        lerr_q <= lerr;
        lrd_q  <= (lerr | bus.lsu_we) ? '0 : lrd[lbank];
      end
      if (if_acc) begin
        ferr_q <= ferr;
        fbun_q <= ferr ? '0 : fbun_d;
      end
      unique case (state_q)
        S_INIT: begin
          clr_q <= clr_q + 1'b1;
          if (clr_q == LAST_C) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          ready_q <= 1'b1;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign bus.lsu_ready  = ready_q;
  assign bus.if_ready   = ready_q;
  assign bus.lsu_rvalid = lrv_q;
  assign bus.lsu_err    = lerr_q;
  assign bus.lsu_rdata  = lrd_q;
  assign bus.if_valid   = fv_q;
  assign bus.if_err     = ferr_q;
  assign bus.if_bundle  = fbun_q;
  assign init_done      = ready_q;

endmodule

// File: tb/tb_vliw_mem_banked.sv
// Self-checking bench for vliw_mem_banked: vector table driven through
// a response scoreboard, plus init and mid-stream reset sequences.
module tb_vliw_mem_banked;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic init_done;

  always #5 clk = ~clk;

  vliw_mem_banked_if #(.ADDR_W(32), .BUNDLE_WORDS(4)) bus ();

  vliw_mem_banked #(
    .DEPTH_WORDS(256), .BUNDLE_WORDS(4), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .init_done(init_done)
  );

  typedef struct {
    string        name;
    logic         lreq;
    logic         we;
    logic [3:0]   be;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  xrd;
    logic         xle;
    logic         freq;
    logic [31:0]  pc;
    logic [127:0] xb;
    logic         xfe;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [32:0]  lq [$];
  logic [128:0] fq [$];
  vec_t tbl [$];

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic vec_t idle(input string n);
    vec_t v;
    v.name = n; v.lreq = 0; v.we = 0; v.be = 0; v.addr = 0;
    v.wdata = 0; v.xrd = 0; v.xle = 0;
    v.freq = 0; v.pc = 0; v.xb = 0; v.xfe = 0;
    return v;
  endfunction

  function automatic vec_t lv(input string n, input logic we,
      input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
      input logic [31:0] xrd, input logic xle);
    vec_t v = idle(n);
    v.lreq = 1; v.we = we; v.be = be; v.addr = a;
    v.wdata = wd; v.xrd = xrd; v.xle = xle;
    return v;
  endfunction

  function automatic vec_t fv(input string n, input logic [31:0] pc,
      input logic [127:0] xb, input logic xfe);
    vec_t v = idle(n);
    v.freq = 1; v.pc = pc; v.xb = xb; v.xfe = xfe;
    return v;
  endfunction

  task automatic set_idle();
    bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_be = 0;
    bus.lsu_addr = 0; bus.lsu_wdata = 0;
    bus.if_req = 0; bus.if_pc = 0;
  endtask

  task automatic respond(input string n);
    logic [32:0]  le;
    logic [128:0] fe;
    chk({n, ".rvalid"}, 128'(bus.lsu_rvalid), 128'(lq.size() != 0));
    if (bus.lsu_rvalid && lq.size() != 0) begin
      le = lq.pop_front();
      chk({n, ".rdata"}, 128'(bus.lsu_rdata), 128'(le[31:0]));
      chk({n, ".lsu_err"}, 128'(bus.lsu_err), 128'(le[32]));
    end
    chk({n, ".if_valid"}, 128'(bus.if_valid), 128'(fq.size() != 0));
    if (bus.if_valid && fq.size() != 0) begin
      fe = fq.pop_front();
      chk({n, ".bundle"}, bus.if_bundle, fe[127:0]);
      chk({n, ".if_err"}, 128'(bus.if_err), 128'(fe[128]));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input vec_t v);
    bus.lsu_req = v.lreq; bus.lsu_we = v.we; bus.lsu_be = v.be;
    bus.lsu_addr = v.addr; bus.lsu_wdata = v.wdata;
    bus.if_req = v.freq; bus.if_pc = v.pc;
    if (v.lreq) lq.push_back({v.xle, v.xrd});
    if (v.freq) fq.push_back({v.xfe, v.xb});
    @(posedge clk);
    #1;
    set_idle();
    respond(v.name);
    @(negedge clk);
  endtask

  task automatic wait_init(input string n);
    int rise = 0;
    int bad = 0;
    bus.lsu_req = 1; bus.lsu_addr = 32'h10;
    bus.if_req = 1; bus.if_pc = 32'h0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      if (bus.lsu_ready) begin
        rise = e;
        break;
      end
      if (init_done || bus.if_ready || bus.lsu_rvalid || bus.if_valid ||
          bus.lsu_err || bus.if_err || bus.lsu_rdata != 0 ||
          bus.if_bundle != 0) bad++;
    end
    set_idle();
    chk({n, ".edges"}, 128'(rise), 128'(64));
    chk({n, ".hold"}, 128'(bad), 128'(0));
    chk({n, ".init_done"}, 128'(init_done), 128'(1));
    chk({n, ".if_ready"}, 128'(bus.if_ready), 128'(1));
    @(negedge clk);
  endtask

  localparam logic [127:0] B8 =
    128'h00000103_00000102_00000101_00000100;

  initial begin
    vec_t v;
    set_idle();

    tbl.push_back(fv("fetch0", 32'h0, '0, 0));
    tbl.push_back(lv("st_full", 1, 4'hF, 32'h10, 32'hAABBCCDD, 0, 0));
    tbl.push_back(lv("st_be5", 1, 4'h5, 32'h10, 32'h11223344, 0, 0));
    tbl.push_back(lv("ld_merge", 0, 4'h0, 32'h10, 0, 32'hAA22CC44, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(lv("st_bun", 1, 4'hF, 32'h20 + 32'(4*i),
                       32'h100 + 32'(i), 0, 0));
    tbl.push_back(fv("fetch20", 32'h20, B8, 0));
    v = lv("collide", 1, 4'hF, 32'h24, 32'hDEADBEEF, 0, 0);
    v.freq = 1; v.pc = 32'h20; v.xb = B8; v.xfe = 0;
    tbl.push_back(v);
    tbl.push_back(lv("ld_after", 0, 4'hF, 32'h24, 0, 32'hDEADBEEF, 0));
    tbl.push_back(lv("ld_misal", 0, 4'hF, 32'h3, 0, 0, 1));
    tbl.push_back(lv("st_oor", 1, 4'hF, 32'h400, 32'hCAFEF00D, 0, 1));
    tbl.push_back(lv("ld_w0", 0, 4'h0, 32'h0, 0, 0, 0));
    tbl.push_back(fv("fetch_oor", 32'h3F4, '0, 1));
    tbl.push_back(fv("fetch_mis", 32'h8, '0, 1));
    tbl.push_back(fv("fetch_top", 32'h3F0, '0, 0));
    tbl.push_back(lv("ld_top", 0, 4'h0, 32'h3FC, 0, 0, 0));
    tbl.push_back(lv("ld_oor", 0, 4'h0, 32'h400, 0, 0, 1));
    tbl.push_back(lv("st_be0", 1, 4'h0, 32'h10, 32'h55555555, 0, 0));
    tbl.push_back(lv("ld_be0", 0, 4'h0, 32'h10, 0, 32'hAA22CC44, 0));

    #3;
    chk("rst.ready", 128'(bus.lsu_ready), 128'(0));
    chk("rst.init_done", 128'(init_done), 128'(0));
    chk("rst.rvalid", 128'(bus.lsu_rvalid), 128'(0));
    chk("rst.bundle", bus.if_bundle, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_init("init1");

    foreach (tbl[i]) drive(tbl[i]);

    drive(idle("gap"));
    chk("rdata_hold", 128'(bus.lsu_rdata), 128'(32'hAA22CC44));

    bus.lsu_req = 1; bus.lsu_addr = 32'h24;
    @(posedge clk);
    #1;
    chk("mid.rvalid_pre", 128'(bus.lsu_rvalid), 128'(1));
    @(posedge clk);
    #1;
    chk("mid.rdata_pre", 128'(bus.lsu_rdata), 128'(32'hDEADBEEF));
    #2;
    rst = 1'b0;
    #1;
    set_idle();
    chk("mid.rvalid", 128'(bus.lsu_rvalid), 128'(0));
    chk("mid.ready", 128'(bus.lsu_ready), 128'(0));
    chk("mid.init_done", 128'(init_done), 128'(0));
    chk("mid.rdata", 128'(bus.lsu_rdata), 128'(0));
    lq.delete();
    fq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_init("init2");

    drive(lv("re_ld24", 0, 4'hF, 32'h24, 0, 0, 0));
    drive(lv("re_ld10", 0, 4'hF, 32'h10, 0, 0, 0));
    drive(fv("re_fetch20", 32'h20, '0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vliw_mem_banked.md
# vliw_mem_banked

Parameterised unified instruction/data memory for the VLIW core. It serves one LSU load/store port with byte enables and one instruction-fetch port that returns a full BUNDLE_WORDS-wide bundle per access. Both ports use a req/ready/valid handshake, return out-of-range and misalignment errors, and zero the array in hardware after reset. It sits between the LSU and fetch stage on one side and the core's memory map on the other, as the next-generation main memory.

## Interface
- DEPTH_WORDS, 256, array size in 32-bit words; power of 2, multiple of BUNDLE_WORDS
- BUNDLE_WORDS, 4, words per fetch bundle; power of 2, ≥1
- ADDR_W, 32, byte-address width of both ports

- clk  in  1  sole clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- lsu_req  in  1  LSU request valid
- lsu_we  in  1  1 = store, 0 = load
- lsu_be  in  4  store byte enables; bit k enables bits [8k+7:8k]; ignored on loads
- lsu_addr  in  ADDR_W  byte address
- lsu_wdata  in  32  store data
- lsu_ready  out  1  LSU port accepts a request this cycle
- lsu_rvalid  out  1  one-cycle pulse: response for the previous accepted request
- lsu_rdata  out  32  load data, or 0 for stores and errors
- lsu_err  out  1  qualified by lsu_rvalid; misaligned or out-of-range
- if_req  in  1  fetch request valid
- if_pc  in  ADDR_W  byte address of the bundle
- if_ready  out  1  fetch port accepts a request this cycle
- if_valid  out  1  one-cycle pulse: bundle response
- if_bundle  out  32*BUNDLE_WORDS  word i at bits [32i+31:32i], taken from word index+i
- if_err  out  1  qualified by if_valid; misaligned or out-of-range
- init_done  out  1  high once array clear has completed

## Operation
- Word index = addr[ADDR_W-1:2].
- LSU error: addr[1:0] ≠ 0, or index ≥ DEPTH_WORDS.
- Fetch error: if_pc[log2(BUNDLE_WORDS)+1:0] ≠ 0, or index+BUNDLE_WORDS-1 ≥ DEPTH_WORDS. A fetch never wraps around the array.
- On error: no array write, rdata/bundle = 0, err = 1.
- Store: only bytes with lsu_be[k]=1 are written. Response has rdata = 0 and err = 0. A store with be = 0 is legal and acts as a no-op.
- Load: returns the full word; lsu_be is ignored.
- FSM states:
  - INIT: entered on reset. An internal counter clears BUNDLE_WORDS words per cycle, starting at word 0. Both ready outputs are 0. After DEPTH_WORDS/BUNDLE_WORDS clear cycles, go to RUN.
  - RUN: lsu_ready = if_ready = 1 every cycle. init_done = 1.
- Both ports may be accepted in the same cycle.
- If a store and a fetch hit the same word in one cycle, the fetch returns the pre-store data.
- The store is always performed.

## Timing
- Reset values: lsu_ready = if_ready = 0, lsu_rvalid = if_valid = 0, lsu_err = if_err = 0, lsu_rdata = 0, if_bundle = 0, init_done = 0, FSM = INIT, counter = 0.
- Asserting rst at any point drops in-flight responses immediately and discards the array contents, which are re-zeroed by INIT.
- INIT length: exactly DEPTH_WORDS/BUNDLE_WORDS rising edges after rst deasserts. ready and init_done go high after the last clear edge; for the defaults, after edge 64.
- Accept condition: req && ready at edge N. Response valid high during cycle N+1, which gives a latency of 1.
- Fully pipelined: back-to-back requests give back-to-back valid pulses.
- A request made while ready = 0 is ignored; there is no queueing.
- rdata, bundle and err update only on a response edge and hold their value between responses.
- A load accepted the cycle after a store to the same word returns the new data.

## Test plan
- Reset then idle:
  - Outputs hold their reset values throughout INIT.
  - init_done and both ready outputs rise after exactly 64 edges.
  - Fetch of pc 0x0 returns an all-zero bundle with if_err = 0.
- Byte-enabled stores:
  - Store 0xAABBCCDD to 0x10 with be = 4'hF, then 0x11223344 with be = 4'b0101.
  - A following load of 0x10 returns 0xAA22CC44 one cycle after acceptance.
- Bundle fetch:
  - Store 0x100+i to words 8..11.
  - Fetch pc 0x20 returns bundle words {0x103, 0x102, 0x101, 0x100} (word 3 down to word 0), if_err = 0.
- Collision:
  - In the same cycle, store 0xDEADBEEF to 0x24 and fetch pc 0x20.
  - Bundle word 1 holds the old value 0x101; a load of 0x24 next cycle returns 0xDEADBEEF.
- Errors:
  - Load at 0x3 gives lsu_err = 1, rdata = 0.
  - Store to 0x400 (index 256) gives lsu_err = 1 and no write; word 0 is unchanged.
  - Fetch at 0x3F4 gives if_err = 1 because it is out of range; fetch at 0x8 gives if_err = 1 because it is misaligned.
- Reset mid-stream:
  - Assert rst while back-to-back loads are in flight.
  - rvalid drops to 0 asynchronously and the block re-enters INIT.
  - Data written earlier reads back as 0 after the new INIT completes.
